// File: rtl/resp_router_if.sv
// Bundle of the request-tag, shared-response and per-requester response signals.
// Latency: none; plain wires between the router and its surroundings.
// Backpressure: carries ready/valid pairs only; no buffering here.
// Ports: slave = resp_router side, master = arbiter/memory/requester side.
interface resp_router_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 27
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              io_req_fire;
    logic              io_req_chosen;
    logic              io_req_ready;

    logic              io_resp_in_ready;
    logic              io_resp_in_valid;
    logic              io_resp_in_bits_valid;
    logic [ADDR_W-1:0] io_resp_in_bits_bits_addr;

    logic              io_resp_out_0_ready;
    logic              io_resp_out_0_valid;
    logic              io_resp_out_0_bits_valid;
    logic [ADDR_W-1:0] io_resp_out_0_bits_bits_addr;

    logic              io_resp_out_1_ready;
    logic              io_resp_out_1_valid;
    logic              io_resp_out_1_bits_valid;
    logic [ADDR_W-1:0] io_resp_out_1_bits_bits_addr;

    logic [CNT_W-1:0]  io_count;
    logic              io_error;

    modport slave (
        input  io_req_fire, io_req_chosen,
        output io_req_ready,
        output io_resp_in_ready,
        input  io_resp_in_valid, io_resp_in_bits_valid, io_resp_in_bits_bits_addr,
        input  io_resp_out_0_ready, io_resp_out_1_ready,
        output io_resp_out_0_valid, io_resp_out_0_bits_valid, io_resp_out_0_bits_bits_addr,
        output io_resp_out_1_valid, io_resp_out_1_bits_valid, io_resp_out_1_bits_bits_addr,
        output io_count, io_error
    );

    modport master (
        output io_req_fire, io_req_chosen,
        input  io_req_ready,
        input  io_resp_in_ready,
        output io_resp_in_valid, io_resp_in_bits_valid, io_resp_in_bits_bits_addr,
        output io_resp_out_0_ready, io_resp_out_1_ready,
        input  io_resp_out_0_valid, io_resp_out_0_bits_valid, io_resp_out_0_bits_bits_addr,
        input  io_resp_out_1_valid, io_resp_out_1_bits_valid, io_resp_out_1_bits_bits_addr,
        input  io_count, io_error
    );
endinterface

// File: rtl/resp_router.sv
// Routes a shared response stream back to requester 0/1 in grant order via an in-order tag FIFO.
// Latency: response routing is combinational (0 cycles); a tag is usable 1 cycle after enqueue.
// Backpressure: only the head-selected requester's ready gates io_resp_in_ready; full FIFO drops io_req_ready.
// Ports: clock, reset (sync, active-high), bus (resp_router_if.slave: tag enqueue, response in, two response outs, count, error).
module resp_router #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 27
) (
    input  logic           clock,
    input  logic           reset,
    resp_router_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] tag;
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             error;

    logic empty;
    logic full;
    logic head;
    logic sel_ready;
    logic enq;
    logic deq;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign head  = tag[rp];

    assign bus.io_req_ready = !full && !reset;

    // Only the port the head tag points at can stall the stream.
    assign sel_ready            = head ? bus.io_resp_out_1_ready : bus.io_resp_out_0_ready;
    assign bus.io_resp_in_ready = !empty && sel_ready && !reset;

    assign bus.io_resp_out_0_valid = bus.io_resp_in_valid && !empty && (head == 1'b0);
    assign bus.io_resp_out_1_valid = bus.io_resp_in_valid && !empty && (head == 1'b1);

    assign bus.io_resp_out_0_bits_valid     = bus.io_resp_in_bits_valid;
    assign bus.io_resp_out_0_bits_bits_addr = bus.io_resp_in_bits_bits_addr;
    assign bus.io_resp_out_1_bits_valid     = bus.io_resp_in_bits_valid;
    assign bus.io_resp_out_1_bits_bits_addr = bus.io_resp_in_bits_bits_addr;

    assign bus.io_count = cnt;
    assign bus.io_error = error;

    assign enq = bus.io_req_fire && bus.io_req_ready;
    assign deq = bus.io_resp_in_valid && bus.io_resp_in_ready;

    // Tag storage needs no reset: entries are only read once cnt says they are valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            tag[wp] <= bus.io_req_chosen;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            error <= 1'b0;
        end else begin
            if (enq) begin
                wp <= wp + PTR_W'(1);
            end
            if (deq) begin
                rp <= rp + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // A fire while full is dropped; a response with no tag has nowhere to go.
            if ((bus.io_req_fire && full) || (bus.io_resp_in_valid && empty)) begin
                error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_resp_router.sv
module tb_resp_router;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 27;

    logic clock;
    logic reset;

    resp_router_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    resp_router #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic              port;
        logic              bv;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            passed++;
        end
    endtask

    // Compare a delivered response against the oldest expected one.
    task automatic observe(input logic port, input logic bv, input logic [ADDR_W-1:0] addr);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_resp: got port %0d addr 0x%0h, required no delivery", port, addr);
        end else begin
            e = exp_q.pop_front();
            check("route_port", 32'(port), 32'(e.port));
            check("route_addr", 32'(addr), 32'(e.addr));
            check("route_bvalid", 32'(bv), 32'(e.bv));
        end
    endtask

    // Monitor: a delivery is a valid/ready pair on an output port, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.io_resp_out_0_valid && bus.io_resp_out_0_ready) begin
                observe(1'b0, bus.io_resp_out_0_bits_valid, bus.io_resp_out_0_bits_bits_addr);
            end
            if (bus.io_resp_out_1_valid && bus.io_resp_out_1_ready) begin
                observe(1'b1, bus.io_resp_out_1_bits_valid, bus.io_resp_out_1_bits_bits_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fire(input logic ch);
        bus.io_req_fire   = 1'b1;
        bus.io_req_chosen = ch;
        tick();
        bus.io_req_fire   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("rst_req_ready", 32'(bus.io_req_ready), 32'd0);
        check("rst_in_ready", 32'(bus.io_resp_in_ready), 32'd0);
        reset = 1'b0;
        #1;
    endtask

    // Present one response and hold it until it transfers (bounded).
    task automatic respond(input logic port, input logic [ADDR_W-1:0] addr, input logic bv);
        exp_t e;
        int   n;
        e.port = port;
        e.bv   = bv;
        e.addr = addr;
        exp_q.push_back(e);
        bus.io_resp_in_valid          = 1'b1;
        bus.io_resp_in_bits_bits_addr = addr;
        bus.io_resp_in_bits_valid     = bv;
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            if (bus.io_resp_in_ready) break;
            n++;
        end
        check("resp_accept", 32'(bus.io_resp_in_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.io_resp_in_valid = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        bus.io_req_fire               = 1'b0;
        bus.io_req_chosen             = 1'b0;
        bus.io_resp_in_valid          = 1'b0;
        bus.io_resp_in_bits_valid     = 1'b0;
        bus.io_resp_in_bits_bits_addr = '0;
        bus.io_resp_out_0_ready       = 1'b1;
        bus.io_resp_out_1_ready       = 1'b1;
        tick();
        do_reset();

        // Reset then idle.
        check("idle_req_ready", 32'(bus.io_req_ready), 32'd1);
        check("idle_count", 32'(bus.io_count), 32'd0);
        check("idle_error", 32'(bus.io_error), 32'd0);
        check("idle_out0_valid", 32'(bus.io_resp_out_0_valid), 32'd0);
        check("idle_out1_valid", 32'(bus.io_resp_out_1_valid), 32'd0);

        // Response on empty FIFO: never delivered, error sticks.
        bus.io_resp_in_valid          = 1'b1;
        bus.io_resp_in_bits_bits_addr = 27'h77;
        #1;
        check("empty_out0_valid", 32'(bus.io_resp_out_0_valid), 32'd0);
        check("empty_out1_valid", 32'(bus.io_resp_out_1_valid), 32'd0);
        check("empty_in_ready", 32'(bus.io_resp_in_ready), 32'd0);
        tick();
        bus.io_resp_in_valid = 1'b0;
        check("empty_error", 32'(bus.io_error), 32'd1);
        tick();
        check("empty_error_sticky", 32'(bus.io_error), 32'd1);
        do_reset();
        check("reset_clears_error", 32'(bus.io_error), 32'd0);

        // In-order routing.
        fire(1'b1);
        check("order_count1", 32'(bus.io_count), 32'd1);
        fire(1'b0);
        check("order_count2", 32'(bus.io_count), 32'd2);
        fire(1'b1);
        check("order_count3", 32'(bus.io_count), 32'd3);
        respond(1'b1, 27'h10, 1'b1);
        respond(1'b0, 27'h20, 1'b0);
        respond(1'b1, 27'h30, 1'b1);
        check("order_count0", 32'(bus.io_count), 32'd0);

        // Head-of-line backpressure: only the head's port matters.
        fire(1'b0);
        fire(1'b1);
        bus.io_resp_out_0_ready = 1'b0;
        bus.io_resp_out_1_ready = 1'b1;
        bus.io_resp_in_valid          = 1'b1;
        bus.io_resp_in_bits_bits_addr = 27'h40;
        bus.io_resp_in_bits_valid     = 1'b1;
        #1;
        check("hol_in_ready", 32'(bus.io_resp_in_ready), 32'd0);
        check("hol_out0_valid", 32'(bus.io_resp_out_0_valid), 32'd1);
        check("hol_out1_valid", 32'(bus.io_resp_out_1_valid), 32'd0);
        tick();
        check("hol_count_holds", 32'(bus.io_count), 32'd2);
        bus.io_resp_out_0_ready = 1'b1;
        respond(1'b0, 27'h40, 1'b1);
        respond(1'b1, 27'h50, 1'b0);
        check("hol_count0", 32'(bus.io_count), 32'd0);

        // Full, overflow drop, then wrap.
        fire(1'b0);
        fire(1'b1);
        fire(1'b1);
        fire(1'b0);
        check("full_count", 32'(bus.io_count), 32'd4);
        check("full_req_ready", 32'(bus.io_req_ready), 32'd0);
        check("full_error_before", 32'(bus.io_error), 32'd0);
        fire(1'b1);
        check("overflow_count", 32'(bus.io_count), 32'd4);
        check("overflow_error", 32'(bus.io_error), 32'd1);
        respond(1'b0, 27'hA0, 1'b1);
        check("unfull_req_ready", 32'(bus.io_req_ready), 32'd1);
        respond(1'b1, 27'hA1, 1'b1);
        check("drain_count", 32'(bus.io_count), 32'd2);
        fire(1'b1);
        fire(1'b0);
        check("wrap_count", 32'(bus.io_count), 32'd4);
        respond(1'b1, 27'hA2, 1'b1);
        respond(1'b0, 27'hA3, 1'b0);
        respond(1'b1, 27'hA4, 1'b1);
        respond(1'b0, 27'hA5, 1'b0);
        check("wrap_count0", 32'(bus.io_count), 32'd0);
        do_reset();

        // Simultaneous enqueue and dequeue at cnt=2.
        fire(1'b0);
        fire(1'b1);
        check("simul_pre_count", 32'(bus.io_count), 32'd2);
        bus.io_req_fire   = 1'b1;
        bus.io_req_chosen = 1'b1;
        respond(1'b0, 27'hB0, 1'b1);
        bus.io_req_fire   = 1'b0;
        check("simul_count", 32'(bus.io_count), 32'd2);
        respond(1'b1, 27'hB1, 1'b1);
        respond(1'b1, 27'hB2, 1'b0);
        check("simul_count0", 32'(bus.io_count), 32'd0);
        check("simul_error", 32'(bus.io_error), 32'd0);

        // Reset mid-operation discards outstanding tags.
        fire(1'b0);
        fire(1'b1);
        fire(1'b0);
        check("mid_count3", 32'(bus.io_count), 32'd3);
        do_reset();
        check("mid_count0", 32'(bus.io_count), 32'd0);
        check("mid_error0", 32'(bus.io_error), 32'd0);
        bus.io_resp_in_valid          = 1'b1;
        bus.io_resp_in_bits_bits_addr = 27'hC0;
        #1;
        check("mid_out0_valid", 32'(bus.io_resp_out_0_valid), 32'd0);
        check("mid_out1_valid", 32'(bus.io_resp_out_1_valid), 32'd0);
        tick();
        bus.io_resp_in_valid = 1'b0;
        check("mid_error1", 32'(bus.io_error), 32'd1);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/resp_router.md
# resp_router

Return-path companion to the two-input priority request arbiter. Each granted request's chosen index is recorded in an in-order tag FIFO. A single shared response stream is then demultiplexed back to the originating requester port, strictly in grant order. The block sits between the memory-side response channel and the two requester response ports.

## Interface
- DEPTH, 4, maximum outstanding requests; power of two, ≥2
- ADDR_W, 27, width of the `bits_bits_addr` payload field
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_req_fire  in  1  arbiter output handshake fired this cycle (arbiter `io_out_valid & io_out_ready`)
- io_req_chosen  in  1  arbiter `io_chosen` for the fired request
- io_req_ready  out  1  tag FIFO can accept; upstream ANDs this into the arbiter's `io_out_ready`
- io_resp_in_ready  out  1  response accepted this cycle
- io_resp_in_valid  in  1  response present
- io_resp_in_bits_valid  in  1  payload valid flag
- io_resp_in_bits_bits_addr  in  ADDR_W  payload
- io_resp_out_0_ready / io_resp_out_1_ready  in  1  requester k can take response
- io_resp_out_0_valid / io_resp_out_1_valid  out  1  response for requester k
- io_resp_out_0_bits_valid / io_resp_out_1_bits_valid  out  1  copy of `io_resp_in_bits_valid`
- io_resp_out_0_bits_bits_addr / io_resp_out_1_bits_bits_addr  out  ADDR_W  copy of `io_resp_in_bits_bits_addr`
- io_count  out  clog2(DEPTH+1)  outstanding (enqueued, not yet responded) tags
- io_error  out  1  sticky protocol-violation flag

## Operation
- State:
  - DEPTH×1-bit tag array
  - write pointer wp and read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register cnt, range 0..DEPTH
  - error register
- Derived signals: empty = (cnt==0), full = (cnt==DEPTH), head = tag[rp].
- io_req_ready = !full && !reset.
- Enqueue: when io_req_fire && io_req_ready:
  - tag[wp] <= io_req_chosen
  - wp <= wp+1
- Routing (combinational):
  - sel_ready = head ? io_resp_out_1_ready : io_resp_out_0_ready.
  - io_resp_in_ready = !empty && sel_ready && !reset.
  - io_resp_out_k_valid = io_resp_in_valid && !empty && (head==k).
  - Payload fields are driven to both outputs unconditionally.
- Dequeue: when io_resp_in_valid && io_resp_in_ready, rp <= rp+1.
- Count update:
  - cnt <= cnt + enq − deq.
  - Simultaneous enq and deq leaves cnt unchanged while both pointers advance.
- No bypass:
  - A tag enqueued in cycle N is usable for routing from cycle N+1.
  - A response in the same cycle as its request on an empty FIFO is a violation.
- Error set (sticky until reset) on either condition:
  - io_req_fire && full: the request is dropped and no tag is written.
  - io_resp_in_valid && empty.
- io_count = cnt; io_error = error.

## Timing
- Reset values, after the first rising edge with reset high:
  - wp=rp=0, cnt=0, error=0, tag array don't-care
  - io_req_ready=1 once reset deasserts
  - io_resp_in_ready=0, both io_resp_out_k_valid=0, io_count=0, io_error=0
- While reset is high, io_req_ready and io_resp_in_ready are forced 0.
- Reset mid-operation discards all outstanding tags; the next response after reset flags error.
- Routing latency: 0 cycles, combinational from io_resp_in_* to io_resp_out_*.
- Tag latency: 1 cycle from enqueue to availability.
- Handshake rules:
  - Response transfer occurs iff io_resp_in_valid && io_resp_in_ready.
  - Upstream holds valid and payload stable until transfer.
  - Backpressure from the non-selected port has no effect.
- Full: io_req_ready drops in the cycle cnt reaches DEPTH. It reasserts the cycle after a dequeue.
- Full plus simultaneous deq and req_fire: the request is rejected and error is set, because io_req_ready is computed from registered cnt.
- Wrap-around: pointers roll DEPTH−1 → 0 with no special-casing. cnt disambiguates full from empty.

## Test plan
- Reset then idle:
  - io_req_ready=1, io_count=0, io_error=0, both out valids 0.
  - io_resp_in_valid=1 on empty → io_error=1 next cycle, stays 1 until reset.
- In-order routing:
  - Fire chosen=1, then 0, then 1 on consecutive cycles, all out readies high.
  - Responses addr 0x10, 0x20, 0x30 → delivered on out_1, out_0, out_1 respectively.
  - io_count goes 1,2,3 then back to 0.
- Head-of-line backpressure:
  - Head tag 0, io_resp_out_0_ready=0, io_resp_out_1_ready=1 → io_resp_in_ready=0, io_resp_out_0_valid=1, rp holds.
  - Raising out_0 ready → transfer and the next tag becomes head.
- Full and wrap:
  - Enqueue 4 tags → io_req_ready=0, io_count=4.
  - A fifth fire → dropped, io_error=1.
  - Drain 2, enqueue 2 (pointer wrap) → the following 4 responses route in original order.
- Simultaneous enq/deq at cnt=2: one fire plus one response transfer in the same cycle → io_count stays 2, order preserved.
- Reset mid-operation:
  - With 3 outstanding, assert reset for 1 cycle → io_count=0, io_error=0.
  - Response arriving after reset → no out valid asserted, io_error=1.
